// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge between the openmips core ROM port and a variable-latency
// req/ack instruction bus. A one-word fetch buffer serves hits in the same cycle.
// A miss stalls the core, runs one bus read, refills the buffer and replays the fetch.
// Bus errors, timeouts and misaligned PCs return NOP_WORD with a one-cycle fetch_err_o.
module inst_fetch_bridge #(
  // BUSY cycles without ack/err before the read is abandoned; must be 1..255
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] NOP_WORD = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        stallreq_o,
  output logic        fetch_err_o,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_data_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state;
  logic        buf_valid;
  logic [31:0] buf_tag;
  logic [31:0] buf_data;
  logic [7:0]  wait_cnt;

  logic        misaligned;
  logic        hit;

  assign misaligned = (rom_addr_i[1:0] != 2'b00);
  assign hit        = buf_valid && (buf_tag == rom_addr_i);

  // Core-facing outputs: decoded from the current state and the live PC so a hit costs no cycle.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    rom_data_o = '0;
    stallreq_o = 1'b0;
    case (state)
      IDLE: begin
        if (rom_ce_i) begin
          if (misaligned)  stallreq_o = 1'b1;
          else if (hit)    rom_data_o = buf_data;
          else             stallreq_o = 1'b1;
        end
      end
      BUSY:    stallreq_o = rom_ce_i;
      ERR:     rom_data_o = NOP_WORD;
      default: ;
    endcase
  end

  // Fetch FSM with registered bus request, error pulse, wait counter and fetch buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the buffer is a handful of flops, not a RAM, so resetting tag and data is cheap and
      // keeps rom_data_o deterministic; only resettable flops belong in this branch.
      state       <= IDLE;
      buf_valid   <= 1'b0;
      buf_tag     <= '0;
      buf_data    <= '0;
      bus_req_o   <= 1'b0;
      bus_addr_o  <= '0;
      wait_cnt    <= '0;
      fetch_err_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; defaults here are overridden by later
      // assignments in the same block, which is what makes bus_req_o/fetch_err_o pulse cleanly.
      bus_req_o   <= 1'b0;
      fetch_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (rom_ce_i) begin
            if (misaligned) begin
              state       <= ERR;
              fetch_err_o <= 1'b1;
            end else if (!hit) begin
              state      <= BUSY;
              bus_req_o  <= 1'b1;
              bus_addr_o <= rom_addr_i;
              wait_cnt   <= '0;
            end
          end
        end
        BUSY: begin
          if (bus_err_i) begin
            // An error terminates the read even if ack arrives in the same cycle.
            state       <= ERR;
            fetch_err_o <= 1'b1;
          end else if (bus_ack_i) begin
            // The buffer is tagged with the latched address, not the live PC; IDLE re-checks the hit.
            buf_data  <= bus_data_i;
            buf_tag   <= bus_addr_o;
            buf_valid <= 1'b1;
            state     <= IDLE;
          end else if (wait_cnt == LAST_CNT) begin
            state       <= ERR;
            fetch_err_o <= 1'b1;
          end else begin
            bus_req_o <= 1'b1;
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
      // Placed last so an invalidate beats a refill landing on the same edge.
      if (flush_i) buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: a small bus responder and a scoreboard queue of
// expected instruction words, pushed when a fetch is issued and popped when it is delivered.
module tb_inst_fetch_bridge;

  localparam int unsigned TIMEOUT  = 4;
  localparam logic [31:0] NOP_WORD = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        fetch_err_o;
  logic        flush_i;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic        bus_err_i;
  logic [31:0] bus_data_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  inst_fetch_bridge #(.TIMEOUT(TIMEOUT), .NOP_WORD(NOP_WORD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .stallreq_o (stallreq_o),
    .fetch_err_o(fetch_err_o),
    .flush_i    (flush_i),
    .bus_req_o  (bus_req_o),
    .bus_addr_o (bus_addr_o),
    .bus_ack_i  (bus_ack_i),
    .bus_err_i  (bus_err_i),
    .bus_data_i (bus_data_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch and serve the bus with ack on the lat-th BUSY cycle.
  // With flush_first_ack the first ack carries a wrong word and a flush, forcing a re-read.
  task automatic fetch(input string tag, input logic [31:0] pc, input int lat,
                       input logic [31:0] data, input int exp_stalls, input bit flush_first_ack);
    int stalls = 0;
    int busy = 0;
    bit done = 0;
    bit flushed = 0;
    logic [31:0] exp_word;
    rom_ce_i = 1'b1;
    rom_addr_i = pc;
    exp_q.push_back(data);
    for (int c = 0; c < 300 && !done; c++) begin
      bus_ack_i = 1'b0;
      flush_i = 1'b0;
      bus_data_i = 32'hDEAD_BEEF;
      if (bus_req_o) begin
        busy++;
        if (busy == lat) begin
          bus_ack_i = 1'b1;
          check({tag, ":bus_addr"}, bus_addr_o, pc);
          if (flush_first_ack && !flushed) begin
            flush_i = 1'b1;
            flushed = 1'b1;
            bus_data_i = ~data;
          end else begin
            bus_data_i = data;
          end
        end
      end else begin
        busy = 0;
      end
      @(negedge clk);
      if (!stallreq_o) begin
        done = 1'b1;
        exp_word = exp_q.pop_front();
        check({tag, ":rom_data"}, rom_data_o, exp_word);
        check({tag, ":stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        check({tag, ":no_req_on_delivery"}, {31'b0, bus_req_o}, 32'd0);
      end else begin
        stalls++;
      end
      tick();
    end
    bus_ack_i = 1'b0;
    flush_i = 1'b0;
    check({tag, ":delivered"}, {31'b0, done}, 32'd1);
  endtask

  // Fetch that must end in a NOP + fetch_err_o pulse.
  // mode 0: no bus response (timeout); mode 1: err+ack together on the 2nd BUSY cycle; mode 2: misaligned PC.
  task automatic err_fetch(input string tag, input logic [31:0] pc, input int mode, input int exp_req);
    int req = 0;
    bit done = 0;
    rom_ce_i = 1'b1;
    rom_addr_i = pc;
    for (int c = 0; c < 300 && !done; c++) begin
      bus_ack_i = 1'b0;
      bus_err_i = 1'b0;
      bus_data_i = 32'hDEAD_BEEF;
      if (bus_req_o) begin
        req++;
        if (mode == 1 && req == 2) begin
          bus_ack_i = 1'b1;
          bus_err_i = 1'b1;
          bus_data_i = 32'hBAD0_BAD0;
        end
      end
      @(negedge clk);
      if (fetch_err_o) begin
        done = 1'b1;
        check({tag, ":nop"}, rom_data_o, NOP_WORD);
        check({tag, ":err_stall"}, {31'b0, stallreq_o}, 32'd0);
        check({tag, ":err_req"}, {31'b0, bus_req_o}, 32'd0);
        check({tag, ":req_cycles"}, 32'(req), 32'(exp_req));
      end else begin
        check({tag, ":stall"}, {31'b0, stallreq_o}, 32'd1);
      end
      tick();
    end
    bus_ack_i = 1'b0;
    bus_err_i = 1'b0;
    check({tag, ":err_seen"}, {31'b0, done}, 32'd1);
    rom_ce_i = 1'b0;
    @(negedge clk);
    check({tag, ":err_pulse_end"}, {31'b0, fetch_err_o}, 32'd0);
    check({tag, ":idle_data"}, rom_data_o, 32'h0);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    rom_ce_i = 1'b0;
    rom_addr_i = '0;
    flush_i = 1'b0;
    bus_ack_i = 1'b1;
    bus_err_i = 1'b0;
    bus_data_i = 32'h1234_5678;

    // 1: reset held two cycles with ack asserted
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      check("rst:rom_data", rom_data_o, 32'h0);
      check("rst:stall", {31'b0, stallreq_o}, 32'd0);
      check("rst:fetch_err", {31'b0, fetch_err_o}, 32'd0);
      check("rst:bus_req", {31'b0, bus_req_o}, 32'd0);
      check("rst:bus_addr", bus_addr_o, 32'h0);
    end
    tick();
    rst = 1'b1;
    bus_ack_i = 1'b0;
    @(negedge clk);
    check("idle_ce0:rom_data", rom_data_o, 32'h0);
    check("idle_ce0:stall", {31'b0, stallreq_o}, 32'd0);
    tick();

    // 2: miss with ack latency 3, then a hit on the same PC
    fetch("t2_miss", 32'h0000_0004, 3, 32'h3401_1100, 4, 1'b0);
    fetch("t2_hit",  32'h0000_0004, 3, 32'h3401_1100, 0, 1'b0);

    // 3: sequential PCs with ack latency 1
    fetch("t3_pc0", 32'h0000_0000, 1, 32'h1111_0000, 2, 1'b0);
    fetch("t3_pc4", 32'h0000_0004, 1, 32'h2222_0004, 2, 1'b0);
    fetch("t3_pc8", 32'h0000_0008, 1, 32'h3333_0008, 2, 1'b0);

    // 4: no response -> timeout after TIMEOUT request cycles
    err_fetch("t4_timeout", 32'h0000_0100, 0, 4);

    // 5: misaligned PC, then err+ack together; buffer must still hold PC 0x8
    err_fetch("t5_misalign", 32'h0000_0002, 2, 0);
    err_fetch("t5_buserr",   32'h0000_0200, 1, 2);
    fetch("t5_keep_hit",  32'h0000_0008, 1, 32'h3333_0008, 0, 1'b0);
    fetch("t5_err_miss",  32'h0000_0200, 1, 32'h2000_0001, 2, 1'b0);

    // 6: flush coincident with ack forces a second read of the same address
    fetch("t6_flush_ack", 32'h0000_0040, 1, 32'h4040_4040, 4, 1'b1);

    // flush during an IDLE hit still delivers this cycle, next fetch misses
    rom_ce_i = 1'b1;
    rom_addr_i = 32'h0000_0040;
    flush_i = 1'b1;
    @(negedge clk);
    check("t6_idle_flush:stall", {31'b0, stallreq_o}, 32'd0);
    check("t6_idle_flush:rom_data", rom_data_o, 32'h4040_4040);
    tick();
    flush_i = 1'b0;
    fetch("t6_after_flush", 32'h0000_0040, 2, 32'h4141_4141, 3, 1'b0);

    // reset in the middle of a BUSY read
    rom_ce_i = 1'b1;
    rom_addr_i = 32'h0000_0080;
    tick();
    @(negedge clk);
    check("t6_busy:bus_req", {31'b0, bus_req_o}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    rom_ce_i = 1'b0;
    @(negedge clk);
    check("t6_rst_busy:bus_req", {31'b0, bus_req_o}, 32'd0);
    check("t6_rst_busy:stall", {31'b0, stallreq_o}, 32'd0);
    tick();
    fetch("t6_rst_invalid", 32'h0000_0040, 1, 32'h4242_4242, 2, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
